input_port_handler: RTL and testbench
=====================================

# input_port_handler

Receive side of a router link: accepts packets driven by a neighbour router's output port, buffers them in a small FIFO, and computes an XY dimension-order route for the head packet. It raises one select bit toward the matching output arbiter (N/S/E/W) or the local cache arbiter, then holds the packet until that consumer grants. One instance sits on each of the four link inputs of every router node.

## Interface
- FIFO_DEPTH, 4, packet FIFO entries; must be a power of two and ≥2.
- PORT_ID, 0, this port's direction: 0=N, 1=S, 2=E, 3=W. Used for U-turn detection.
- NA_W, `NETWORK_ADDRESS_WIDTH, node address width, {x,y} with x in the upper NA_W/2 bits.
- CB_W, `CACHE_BANK_ADDRESS_WIDTH, cache bank address width.
- DW, `DATA_WIDTH, data width.

- clk  in  1  all registers update on negedge clk.
- reset  in  1  reset, synchronous, active-high.
- localAddress  in  NA_W  this node's {x,y}.
- destinationAddressIn  in  NA_W+CB_W  destination {node, bank}.
- requesterAddressIn  in  NA_W  originating node.
- readIn, writeIn  in  1 each  packet valid when either is high; both high is illegal.
- dataIn  in  DW  payload.
- stallOut  out  1  FIFO full; the upstream port must hold off.
- selectBit_NORTH/SOUTH/EAST/WEST/LOCAL  out  1 each  one-hot route request for the head packet.
- grant  in  5  {LOCAL,W,E,S,N} accept from consumers.
- destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut  out  as inputs  head packet fields, broadcast to all consumers.
- occupancy  out  $clog2(FIFO_DEPTH)+1  FIFO count, not including the head register.
- overflowError, routeError  out  1 each  sticky error flags.

## Operation
- Push: a valid packet is written to the FIFO on a clock edge when count < FIFO_DEPTH.
  - If count == FIFO_DEPTH, the packet is dropped and overflowError is set, even if a pop happens on the same edge.
- Head register:
  - When the head is empty or popping this edge and the FIFO is non-empty, the FIFO front is loaded into the head.
  - The route is computed from that entry and registered alongside it.
- Route (dest node = {dx,dy}, local = {lx,ly}, unsigned compare):
  - dx>lx → EAST; dx<lx → WEST.
  - Otherwise dy>ly → NORTH; dy<ly → SOUTH; else LOCAL.
- U-turn: if the computed route equals PORT_ID's direction, the packet is discarded at head load and routeError is set.
  - The next FIFO entry is eligible on the following edge.
- Select bits are high only while the head is valid; exactly one is high.
- Pop: head clears on an edge where (select & grant) != 0.
  - Grant bits for unselected directions are ignored.
  - Back-to-back pops are allowed: head reloads on the same edge.
- States: EMPTY (head invalid) and HOLD (head valid, waiting for grant).
  - EMPTY→HOLD on load; HOLD→EMPTY on pop with FIFO empty; HOLD→HOLD on pop with reload.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is one bit wider, so full and empty are unambiguous.
- Simultaneous push and pop with 0<count<FIFO_DEPTH: count unchanged.

## Timing
- Reset values:
  - Outputs: all select bits 0, readOut/writeOut 0, address/data outputs 0.
  - Status: stallOut 0, occupancy 0, both error flags 0.
  - Internal: pointers 0.
- Reset mid-operation drops all buffered and head packets; no select is asserted on the cycle after reset.
- Latency: a packet pushed at edge N into an empty FIFO with an empty head loads into the head at edge N+1. Select is visible after N+1, so the earliest pop is at N+2.
- Throughput: one packet per cycle with continuous grant.
- stallOut = (count == FIFO_DEPTH), derived from registered count; it does not see same-cycle pops.
- Error flags stay set until reset.

## Structure
- globalVariables.v holds NETWORK_ADDRESS_WIDTH, CACHE_BANK_ADDRESS_WIDTH, DATA_WIDTH.
- It also gets new constants PORT_NORTH..PORT_WEST (0..3) and ROUTE_LOCAL index 4 for the grant/select bit order.
- One sub-module, packet_fifo: parameterized depth/width storage with count.
  - Packet fields are concatenated into a single word.
  - Routing logic and the head register stay in input_port_handler.

## Test plan
- localAddress={2,2}, PORT_ID=0, push write to node {3,2} bank 5, grant[2] held high → selectBit_EAST after N+1, pop at N+2, occupancy back to 0.
- Push to {2,2} with grant=0 for 10 cycles → selectBit_LOCAL stays high, fields stable; grant[4] → pop.
- Push 5 packets to {0,2} with grant=0, FIFO_DEPTH=4 → first loads head, next 4 fill FIFO, stallOut=1. A 6th push sets overflowError with occupancy still 4; then grant[3] continuous drains 5 packets in order on 5 consecutive edges.
- PORT_ID=1 (S), push to {2,1} → routeError=1, no select raised; following packet to {1,2} routes WEST normally.
- Push then assert reset while head valid → all outputs 0 next cycle, occupancy 0, subsequent push routes correctly.
- Stream 8 packets with grant always matching the route, pointers wrapping twice → order preserved, no errors, stallOut never 1.

Source files
------------

// File: rtl/input_port_handler_pkg.sv
// Shared constants for the router input port: link widths, grant/select bit order, head FSM states.
package input_port_handler_pkg;

  localparam int NETWORK_ADDRESS_WIDTH    = 6;
  localparam int CACHE_BANK_ADDRESS_WIDTH = 4;
  localparam int DATA_WIDTH               = 16;

  localparam int PORT_NORTH  = 0;
  localparam int PORT_SOUTH  = 1;
  localparam int PORT_EAST   = 2;
  localparam int PORT_WEST   = 3;
  localparam int ROUTE_LOCAL = 4;
  localparam int ROUTE_W     = 5;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } head_state_t;

  function automatic logic [ROUTE_W-1:0] dir_onehot(input int idx);
    logic [ROUTE_W-1:0] onehot;
    for (int i = 0; i < ROUTE_W; i++) begin
      onehot[i] = (i == idx);
    end
    return onehot;
  endfunction

endpackage

// File: rtl/input_port_handler_packet_fifo.sv
// Packet buffer for the input port: power-of-two depth, naturally wrapping pointers, count one bit wider.
module packet_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && (count != FULL_COUNT);
  assign pop_ok_s  = pop && (count != '0);
  assign rdata     = mem_r[rd_ptr_r];

  // Storage array; contents are only observed while count is non-zero, so no reset.
  always_ff @(negedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and count bookkeeping.
  always_ff @(negedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count    <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count <= count + (AW+1)'(1'b1);
        2'b01:   count <= count - (AW+1)'(1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_port_handler.sv
// Router link receive port: buffers incoming packets, XY-routes the head packet and holds it
// with a one-hot select until the chosen consumer grants.
module input_port_handler
  import input_port_handler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PORT_ID    = PORT_NORTH,
  parameter int NA_W       = NETWORK_ADDRESS_WIDTH,
  parameter int CB_W       = CACHE_BANK_ADDRESS_WIDTH,
  parameter int DW         = DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NA_W-1:0]              localAddress,
  input  logic [NA_W+CB_W-1:0]         destinationAddressIn,
  input  logic [NA_W-1:0]              requesterAddressIn,
  input  logic                         readIn,
  input  logic                         writeIn,
  input  logic [DW-1:0]                dataIn,
  output logic                         stallOut,
  output logic                         selectBit_NORTH,
  output logic                         selectBit_SOUTH,
  output logic                         selectBit_EAST,
  output logic                         selectBit_WEST,
  output logic                         selectBit_LOCAL,
  input  logic [ROUTE_W-1:0]           grant,
  output logic [NA_W+CB_W-1:0]         destinationAddressOut,
  output logic [NA_W-1:0]              requesterAddressOut,
  output logic                         readOut,
  output logic                         writeOut,
  output logic [DW-1:0]                dataOut,
  output logic [$clog2(FIFO_DEPTH):0]  occupancy,
  output logic                         overflowError,
  output logic                         routeError
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DA_W  = NA_W + CB_W;
  localparam int PKT_W = DA_W + NA_W + 2 + DW;
  localparam int HW    = NA_W / 2;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  head_state_t         state_r;
  logic [ROUTE_W-1:0]  select_r;
  logic [ROUTE_W-1:0]  route_s;
  logic [PKT_W-1:0]    push_word_s;
  logic [PKT_W-1:0]    front_s;
  logic [CW-1:0]       count_s;
  logic [DA_W-1:0]     f_dest_s;
  logic [NA_W-1:0]     f_req_s;
  logic                f_read_s;
  logic                f_write_s;
  logic [DW-1:0]       f_data_s;
  logic                pkt_valid_s;
  logic                drop_s;
  logic                fire_s;
  logic                head_free_s;
  logic                load_s;
  logic                uturn_s;
  logic                take_s;

  // XY dimension-order routing: resolve x first, then y, else deliver locally.
  function automatic logic [ROUTE_W-1:0] route_xy(input logic [NA_W-1:0] dst,
                                                  input logic [NA_W-1:0] loc);
    logic [HW-1:0] dx, dy, lx, ly;
    dx = dst[NA_W-1 -: HW];
    dy = dst[HW-1:0];
    lx = loc[NA_W-1 -: HW];
    ly = loc[HW-1:0];
    if (dx > lx)      return dir_onehot(PORT_EAST);
    else if (dx < lx) return dir_onehot(PORT_WEST);
    else if (dy > ly) return dir_onehot(PORT_NORTH);
    else if (dy < ly) return dir_onehot(PORT_SOUTH);
    else              return dir_onehot(ROUTE_LOCAL);
  endfunction

  assign pkt_valid_s = readIn | writeIn;
  assign drop_s      = pkt_valid_s && (count_s == FULL_COUNT);
  assign push_word_s = {destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn};

  packet_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pkt_valid_s && !drop_s),
    .pop   (load_s),
    .wdata (push_word_s),
    .rdata (front_s),
    .count (count_s)
  );

  assign {f_dest_s, f_req_s, f_read_s, f_write_s, f_data_s} = front_s;

  // A head that would go back out the link it arrived on is discarded at load.
  assign route_s     = route_xy(f_dest_s[DA_W-1 -: NA_W], localAddress);
  assign uturn_s     = route_s[PORT_ID];
  assign fire_s      = (state_r == ST_HOLD) && ((select_r & grant) != '0);
  assign head_free_s = (state_r == ST_EMPTY) || fire_s;
  assign load_s      = head_free_s && (count_s != '0);
  assign take_s      = load_s && !uturn_s;

  assign stallOut        = (count_s == FULL_COUNT);
  assign occupancy       = count_s;
  assign selectBit_NORTH = select_r[PORT_NORTH];
  assign selectBit_SOUTH = select_r[PORT_SOUTH];
  assign selectBit_EAST  = select_r[PORT_EAST];
  assign selectBit_WEST  = select_r[PORT_WEST];
  assign selectBit_LOCAL = select_r[ROUTE_LOCAL];

  // Head FSM with registered packet fields, route select and sticky error flags.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_r               <= ST_EMPTY;
      select_r              <= '0;
      destinationAddressOut <= '0;
      requesterAddressOut   <= '0;
      readOut               <= 1'b0;
      writeOut              <= 1'b0;
      dataOut               <= '0;
      overflowError         <= 1'b0;
      routeError            <= 1'b0;
    end else begin
      if (drop_s) begin
        overflowError <= 1'b1;
      end
      if (load_s && uturn_s) begin
        routeError <= 1'b1;
      end
      if (take_s) begin
        state_r               <= ST_HOLD;
        select_r              <= route_s;
        destinationAddressOut <= f_dest_s;
        requesterAddressOut   <= f_req_s;
        readOut               <= f_read_s;
        writeOut              <= f_write_s;
        dataOut               <= f_data_s;
      end else if (head_free_s) begin
        state_r  <= ST_EMPTY;
        select_r <= '0;
        readOut  <= 1'b0;
        writeOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_port_handler.sv
// Self-checking bench for input_port_handler: scoreboard of expected head packets popped on each grant.
module tb_input_port_handler;
  import input_port_handler_pkg::*;

  localparam int NA_W = NETWORK_ADDRESS_WIDTH;
  localparam int CB_W = CACHE_BANK_ADDRESS_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam logic [4:0] S_N = 5'b00001;
  localparam logic [4:0] S_S = 5'b00010;
  localparam logic [4:0] S_E = 5'b00100;
  localparam logic [4:0] S_W = 5'b01000;
  localparam logic [4:0] S_L = 5'b10000;

  typedef struct {
    logic [NA_W+CB_W-1:0] dest;
    logic [NA_W-1:0]      req;
    logic                 rd;
    logic                 wr;
    logic [DW-1:0]        data;
    logic [4:0]           sel;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NA_W-1:0]      localAddress;
  logic [NA_W+CB_W-1:0] destinationAddressIn;
  logic [NA_W-1:0]      requesterAddressIn;
  logic                 readIn, writeIn;
  logic [DW-1:0]        dataIn;
  logic [4:0]           grant, grant_s;

  logic                 stallOut, sN, sS, sE, sW, sL;
  logic [NA_W+CB_W-1:0] destinationAddressOut;
  logic [NA_W-1:0]      requesterAddressOut;
  logic                 readOut, writeOut;
  logic [DW-1:0]        dataOut;
  logic [2:0]           occupancy;
  logic                 overflowError, routeError;

  logic                 stall_s, sN_s, sS_s, sE_s, sW_s, sL_s;
  logic [NA_W+CB_W-1:0] dest_s;
  logic [NA_W-1:0]      req_s;
  logic                 rd_s, wr_s;
  logic [DW-1:0]        data_s;
  logic [2:0]           occ_s;
  logic                 ovf_s, rerr_s;

  logic [4:0] sel, sel_s;
  assign sel   = {sL, sW, sE, sS, sN};
  assign sel_s = {sL_s, sW_s, sE_s, sS_s, sN_s};

  always #5 clk = ~clk;

  input_port_handler #(.FIFO_DEPTH(4), .PORT_ID(0)) dut (
    .clk(clk), .reset(reset), .localAddress(localAddress),
    .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn),
    .readIn(readIn), .writeIn(writeIn), .dataIn(dataIn), .stallOut(stallOut),
    .selectBit_NORTH(sN), .selectBit_SOUTH(sS), .selectBit_EAST(sE),
    .selectBit_WEST(sW), .selectBit_LOCAL(sL), .grant(grant),
    .destinationAddressOut(destinationAddressOut), .requesterAddressOut(requesterAddressOut),
    .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut), .occupancy(occupancy),
    .overflowError(overflowError), .routeError(routeError)
  );

  input_port_handler #(.FIFO_DEPTH(4), .PORT_ID(1)) dut_s (
    .clk(clk), .reset(reset), .localAddress(localAddress),
    .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn),
    .readIn(readIn), .writeIn(writeIn), .dataIn(dataIn), .stallOut(stall_s),
    .selectBit_NORTH(sN_s), .selectBit_SOUTH(sS_s), .selectBit_EAST(sE_s),
    .selectBit_WEST(sW_s), .selectBit_LOCAL(sL_s), .grant(grant_s),
    .destinationAddressOut(dest_s), .requesterAddressOut(req_s),
    .readOut(rd_s), .writeOut(wr_s), .dataOut(data_s), .occupancy(occ_s),
    .overflowError(ovf_s), .routeError(rerr_s)
  );

  task automatic drive(input logic [2:0] x, input logic [2:0] y, input logic [3:0] bank,
                       input logic [15:0] d, input logic wr, input logic [4:0] exp_sel,
                       input bit accept);
    exp_t e;
    destinationAddressIn = {x, y, bank};
    requesterAddressIn   = 6'o13;
    readIn               = ~wr;
    writeIn              = wr;
    dataIn               = d;
    if (accept) begin
      e.dest = {x, y, bank}; e.req = 6'o13; e.rd = ~wr; e.wr = wr; e.data = d; e.sel = exp_sel;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    readIn  = 1'b0;
    writeIn = 1'b0;
  endtask

  // One active (negative) edge; a grant that matches the select pops the scoreboard first.
  task automatic edge_step();
    exp_t e;
    if ((sel & grant) != 5'd0) begin
      pops++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: head %h with no packet expected", destinationAddressOut);
      end else begin
        e = sb.pop_front();
        if ({destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut, sel} !==
            {e.dest, e.req, e.rd, e.wr, e.data, e.sel}) begin
          errors++;
          $display("FAIL pop_fields: got dest=%h req=%h r=%b w=%b data=%h sel=%b, want dest=%h req=%h r=%b w=%b data=%h sel=%b",
                   destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut, sel,
                   e.dest, e.req, e.rd, e.wr, e.data, e.sel);
        end
      end
    end
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic do_reset();
    idle();
    grant   = 5'd0;
    grant_s = 5'd0;
    reset   = 1'b1;
    edge_step();
    edge_step();
    reset   = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sel, readOut, writeOut, destinationAddressOut, requesterAddressOut, dataOut} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: sel=%b r=%b w=%b dest=%h req=%h data=%h, want all 0",
               sel, readOut, writeOut, destinationAddressOut, requesterAddressOut, dataOut);
    end
    checks++;
    if ({stallOut, occupancy, overflowError, routeError} !== 6'd0) begin
      errors++;
      $display("FAIL reset_status: stall=%b occ=%0d ovf=%b rerr=%b, want 0",
               stallOut, occupancy, overflowError, routeError);
    end
  endtask

  task automatic test_route_east();
    grant = S_E;
    drive(3'd3, 3'd2, 4'd5, 16'hA5A5, 1'b1, S_E, 1'b1);
    edge_step();
    idle();
    checks++;
    if (occupancy !== 3'd1 || sel !== 5'd0) begin
      errors++;
      $display("FAIL east_latency: occ=%0d sel=%b, want occ=1 sel=00000", occupancy, sel);
    end
    edge_step();
    checks++;
    if (sel !== S_E || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL east_select: sel=%b occ=%0d, want sel=%b occ=0", sel, occupancy, S_E);
    end
    edge_step();
    checks++;
    if (sel !== 5'd0 || occupancy !== 3'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL east_pop: sel=%b occ=%0d pending=%0d, want 0 0 0", sel, occupancy, sb.size());
    end
    grant = 5'd0;
  endtask

  task automatic test_local_hold();
    int bad;
    bad   = 0;
    grant = 5'b01111;
    drive(3'd2, 3'd2, 4'd1, 16'h1234, 1'b0, S_L, 1'b1);
    edge_step();
    idle();
    edge_step();
    for (int i = 0; i < 10; i++) begin
      if (sel !== S_L || destinationAddressOut !== {3'd2, 3'd2, 4'd1} || dataOut !== 16'h1234 ||
          readOut !== 1'b1 || writeOut !== 1'b0) begin
        bad++;
      end
      edge_step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL local_hold: %0d unstable cycles, want 0 (sel=%b dest=%h data=%h)",
               bad, sel, destinationAddressOut, dataOut);
    end
    grant = S_L;
    edge_step();
    grant = 5'd0;
    checks++;
    if (sel !== 5'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL local_pop: sel=%b pending=%0d, want 00000 0", sel, sb.size());
    end
  endtask

  task automatic test_overflow();
    grant = 5'd0;
    for (int i = 0; i < 5; i++) begin
      drive(3'd0, 3'd2, 4'(i), 16'h0100 + 16'(i), 1'b1, S_W, 1'b1);
      edge_step();
    end
    checks++;
    if (stallOut !== 1'b1 || occupancy !== 3'd4 || sel !== S_W) begin
      errors++;
      $display("FAIL fifo_full: stall=%b occ=%0d sel=%b, want 1 4 %b", stallOut, occupancy, sel, S_W);
    end
    drive(3'd0, 3'd2, 4'd9, 16'hDEAD, 1'b1, S_W, 1'b0);
    edge_step();
    idle();
    checks++;
    if (overflowError !== 1'b1 || occupancy !== 3'd4) begin
      errors++;
      $display("FAIL overflow: ovf=%b occ=%0d, want 1 4", overflowError, occupancy);
    end
    pops  = 0;
    grant = S_W;
    for (int i = 0; i < 5; i++) begin
      edge_step();
    end
    grant = 5'd0;
    checks++;
    if (pops != 5 || sb.size() != 0 || sel !== 5'd0 || occupancy !== 3'd0 || stallOut !== 1'b0) begin
      errors++;
      $display("FAIL drain: pops=%0d pending=%0d sel=%b occ=%0d stall=%b, want 5 0 00000 0 0",
               pops, sb.size(), sel, occupancy, stallOut);
    end
    checks++;
    if (overflowError !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b, want 1", overflowError);
    end
  endtask

  task automatic test_reset_mid();
    grant = 5'd0;
    drive(3'd3, 3'd2, 4'd2, 16'h7777, 1'b1, S_E, 1'b1);
    edge_step();
    drive(3'd1, 3'd2, 4'd3, 16'h8888, 1'b1, S_W, 1'b1);
    edge_step();
    idle();
    reset = 1'b1;
    sb.delete();
    edge_step();
    checks++;
    if ({sel, readOut, writeOut, destinationAddressOut, requesterAddressOut, dataOut,
         stallOut, occupancy, overflowError, routeError} !== '0) begin
      errors++;
      $display("FAIL reset_mid: sel=%b r=%b w=%b dest=%h data=%h occ=%0d ovf=%b rerr=%b, want all 0",
               sel, readOut, writeOut, destinationAddressOut, dataOut, occupancy, overflowError, routeError);
    end
    reset = 1'b0;
    edge_step();
    checks++;
    if (sel !== 5'd0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL after_reset: sel=%b occ=%0d, want 00000 0", sel, occupancy);
    end
    grant = S_E;
    drive(3'd4, 3'd6, 4'd4, 16'h4242, 1'b1, S_E, 1'b1);
    edge_step();
    idle();
    edge_step();
    checks++;
    if (sel !== S_E) begin
      errors++;
      $display("FAIL post_reset_route: sel=%b, want %b", sel, S_E);
    end
    edge_step();
    grant = 5'd0;
  endtask

  task automatic test_uturn();
    do_reset();
    drive(3'd2, 3'd1, 4'd6, 16'h0BAD, 1'b1, S_S, 1'b0);
    edge_step();
    drive(3'd1, 3'd2, 4'd7, 16'h600D, 1'b0, S_W, 1'b0);
    edge_step();
    idle();
    checks++;
    if (rerr_s !== 1'b1 || sel_s !== 5'd0) begin
      errors++;
      $display("FAIL uturn_drop: rerr=%b sel=%b, want 1 00000", rerr_s, sel_s);
    end
    edge_step();
    checks++;
    if (sel_s !== S_W || dest_s !== {3'd1, 3'd2, 4'd7} || data_s !== 16'h600D || rerr_s !== 1'b1) begin
      errors++;
      $display("FAIL uturn_next: sel=%b dest=%h data=%h rerr=%b, want %b %h 600d 1",
               sel_s, dest_s, data_s, rerr_s, S_W, {3'd1, 3'd2, 4'd7});
    end
    grant_s = S_W;
    edge_step();
    grant_s = 5'd0;
    checks++;
    if (sel_s !== 5'd0) begin
      errors++;
      $display("FAIL uturn_pop: sel=%b, want 00000", sel_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] xs [8] = '{3'd3, 3'd1, 3'd2, 3'd2, 3'd7, 3'd0, 3'd2, 3'd2};
    logic [2:0] ys [8] = '{3'd2, 3'd2, 3'd0, 3'd2, 3'd2, 3'd2, 3'd1, 3'd2};
    logic [4:0] ss [8] = '{S_E, S_W, S_S, S_L, S_E, S_W, S_S, S_L};
    int stalls;
    stalls = 0;
    do_reset();
    pops  = 0;
    grant = 5'b11111;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(xs[i], ys[i], 4'(i), 16'h5000 + 16'(i), i[0], ss[i], 1'b1);
      else idle();
      if (stallOut !== 1'b0) stalls++;
      edge_step();
    end
    grant = 5'd0;
    checks++;
    if (pops != 8 || sb.size() != 0 || stalls != 0) begin
      errors++;
      $display("FAIL stream: pops=%0d pending=%0d stall_cycles=%0d, want 8 0 0", pops, sb.size(), stalls);
    end
    checks++;
    if (overflowError !== 1'b0 || routeError !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL stream_status: ovf=%b rerr=%b occ=%0d, want 0 0 0", overflowError, routeError, occupancy);
    end
  endtask

  initial begin
    reset        = 1'b1;
    localAddress = {3'd2, 3'd2};
    grant        = 5'd0;
    grant_s      = 5'd0;
    destinationAddressIn = '0;
    requesterAddressIn   = '0;
    dataIn       = '0;
    idle();
    @(posedge clk);
    test_reset();
    test_route_east();
    test_local_hold();
    test_overflow();
    test_reset_mid();
    test_uturn();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
